// File: rtl/dbg_led_panel_if.sv
// Board-side bundle for the debug LED panel: CPU debug taps and switches in,
// seven-segment and status LED drives out.
interface dbg_led_panel_if #(
  parameter int ADDR_W   = 12,
  parameter int SEL_W    = 3,
  parameter int N_DIGITS = 8
);
  logic                      run_sw;
  logic [SEL_W-1:0]          sel;
  logic [ADDR_W-1:0]         in_addr;
  logic [4*N_DIGITS-1:0]     pc;
  logic                      ins_valid;
  logic                      br_valid;
  logic                      br_taken;
  logic                      clr;
  logic                      freeze;
  logic [ADDR_W+SEL_W:0]     leds;
  logic [7:0]                seg;
  logic [N_DIGITS-1:0]       an;

  modport master (
    output run_sw, sel, in_addr, pc, ins_valid, br_valid, br_taken, clr, freeze,
    input  leds, seg, an
  );

  modport slave (
    input  run_sw, sel, in_addr, pc, ins_valid, br_valid, br_taken, clr, freeze,
    output leds, seg, an
  );
endinterface

// File: rtl/dbg_led_panel.sv
// Debug panel: saturating pipeline event counters, a selectable display value
// and a time-multiplexed hex seven-segment scanner with a registered LED bar.
module dbg_led_panel #(
  parameter int ADDR_W   = 12,
  parameter int SEL_W    = 3,
  parameter int N_DIGITS = 8,
  parameter int SCAN_DIV = 50000
) (
  input logic          clk,
  input logic          reset,
  dbg_led_panel_if.slave bus
);
  localparam int DW    = 4 * N_DIGITS;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  logic [DW-1:0]         cyc_cnt, ins_cnt, br_cnt, tk_cnt;
  logic [DW-1:0]         disp_val, mux_val;
  logic [DIV_W-1:0]      div_cnt;
  logic [IDX_W-1:0]      idx, idx_next;
  logic                  div_wrap;
  logic [3:0]            nibble;
  logic [7:0]            seg_q;
  logic [N_DIGITS-1:0]   an_q;
  logic [ADDR_W+SEL_W:0] leds_q;

  function automatic logic [DW-1:0] sat_inc(input logic [DW-1:0] v);
    return (&v) ? v : v + DW'(1);
  endfunction

  function automatic logic [7:0] hex_seg(input logic [3:0] h);
    logic [7:0] p;
    case (h)
      4'h0: p = 8'hC0;  4'h1: p = 8'hF9;  4'h2: p = 8'hA4;  4'h3: p = 8'hB0;
      4'h4: p = 8'h99;  4'h5: p = 8'h92;  4'h6: p = 8'h82;  4'h7: p = 8'hF8;
      4'h8: p = 8'h80;  4'h9: p = 8'h90;  4'hA: p = 8'h88;  4'hB: p = 8'h83;
      4'hC: p = 8'hC6;  4'hD: p = 8'hA1;  4'hE: p = 8'h86;  default: p = 8'h8E;
    endcase
    return p;
  endfunction

  always_comb begin
    mux_val = '0;
    case (bus.sel[2:0])
      3'b000:  mux_val = DW'(bus.in_addr);
      3'b001:  mux_val = bus.pc;
      3'b010:  mux_val = cyc_cnt;
      3'b011:  mux_val = br_cnt;
      3'b100:  mux_val = tk_cnt;
      3'b101:  mux_val = ins_cnt;
      default: mux_val = '0;
    endcase
  end

  // seg and an are both loaded from the next digit index so they switch together
  always_comb begin
    div_wrap = (div_cnt == DIV_LAST);
    idx_next = idx;
    if (div_wrap) idx_next = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    nibble = disp_val[4*idx_next +: 4];
  end

  // clr outranks every increment, including the free-running cycle count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_cnt <= '0;
      ins_cnt <= '0;
      br_cnt  <= '0;
      tk_cnt  <= '0;
    end else if (bus.clr) begin
      cyc_cnt <= '0;
      ins_cnt <= '0;
      br_cnt  <= '0;
      tk_cnt  <= '0;
    end else if (bus.run_sw) begin
      cyc_cnt <= sat_inc(cyc_cnt);
      if (bus.ins_valid) ins_cnt <= sat_inc(ins_cnt);
      if (bus.br_valid) br_cnt <= sat_inc(br_cnt);
      if (bus.br_valid && bus.br_taken) tk_cnt <= sat_inc(tk_cnt);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      disp_val <= '0;
      div_cnt  <= '0;
      idx      <= '0;
      seg_q    <= 8'hC0;
      an_q     <= ~N_DIGITS'(1);
      leds_q   <= '0;
    end else begin
      if (!bus.freeze) disp_val <= mux_val;
      div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
      idx     <= idx_next;
      seg_q   <= hex_seg(nibble);
      an_q    <= ~(N_DIGITS'(1) << idx_next);
      leds_q  <= {bus.run_sw, bus.in_addr, bus.sel};
    end
  end

  assign bus.seg  = seg_q;
  assign bus.an   = an_q;
  assign bus.leds = leds_q;
endmodule

// File: tb/tb_dbg_led_panel.sv
// Directed bench for dbg_led_panel with a fast scan (SCAN_DIV=4) so every
// digit can be observed within a few dozen cycles.
module tb_dbg_led_panel;
  localparam int ADDR_W   = 12;
  localparam int SEL_W    = 3;
  localparam int N_DIGITS = 8;
  localparam int SCAN_DIV = 4;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  logic [7:0] seen_seg [8];

  dbg_led_panel_if #(.ADDR_W(ADDR_W), .SEL_W(SEL_W), .N_DIGITS(N_DIGITS)) bus ();

  dbg_led_panel #(
    .ADDR_W(ADDR_W), .SEL_W(SEL_W), .N_DIGITS(N_DIGITS), .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Records the segment pattern shown for each digit over a full scan period
  task automatic collect_digits;
    logic [7:0] pat;
    for (int k = 0; k < 8; k++) seen_seg[k] = 8'hxx;
    repeat (3) @(negedge clk);
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        pat = ~(8'h01 << k);
        if (bus.an === pat) seen_seg[k] = bus.seg;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    bus.run_sw = 0; bus.sel = 3'b010; bus.in_addr = '0; bus.pc = '0;
    bus.ins_valid = 0; bus.br_valid = 0; bus.br_taken = 0; bus.clr = 0; bus.freeze = 0;
    @(posedge clk);
    #2;
    checks++;
    if (bus.an !== 8'hFE) begin errors++; $display("[TB] FAIL reset_an: got %h expected FE", bus.an); end
    checks++;
    if (bus.seg !== 8'hC0) begin errors++; $display("[TB] FAIL reset_seg: got %h expected C0", bus.seg); end
    checks++;
    if (bus.leds !== 16'h0000) begin errors++; $display("[TB] FAIL reset_leds: got %h expected 0000", bus.leds); end
    checks++;
    if (dut.cyc_cnt !== 32'h0) begin errors++; $display("[TB] FAIL reset_cyc: got %h expected 0", dut.cyc_cnt); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_scan;
    logic [7:0] exp_an;
    for (int k = 0; k <= 32; k++) begin
      if (k > 0) @(negedge clk);
      exp_an = ~(8'h01 << ((k / 4) % 8));
      checks++;
      if (bus.an !== exp_an) begin
        errors++;
        $display("[TB] FAIL scan_an step %0d: got %h expected %h", k, bus.an, exp_an);
      end
    end
  endtask

  task automatic test_cycle_count;
    logic [7:0] exp_seg;
    bus.run_sw = 1;
    repeat (10) @(negedge clk);
    bus.run_sw = 0;
    checks++;
    if (dut.cyc_cnt !== 32'h0000000A) begin errors++; $display("[TB] FAIL cyc_cnt: got %h expected 0000000A", dut.cyc_cnt); end
    collect_digits();
    for (int k = 0; k < 8; k++) begin
      exp_seg = (k == 0) ? 8'h88 : 8'hC0;
      checks++;
      if (seen_seg[k] !== exp_seg) begin errors++; $display("[TB] FAIL cyc_digit%0d: got %h expected %h", k, seen_seg[k], exp_seg); end
    end
  endtask

  task automatic test_branches;
    bus.run_sw = 1;
    for (int i = 0; i < 5; i++) begin
      bus.br_valid = 1; bus.br_taken = (i < 3);
      @(negedge clk);
      bus.br_valid = 0; bus.br_taken = 0;
      @(negedge clk);
    end
    bus.br_taken = 1;
    @(negedge clk);
    bus.br_taken = 0;
    bus.run_sw = 0;
    checks++;
    if (dut.br_cnt !== 32'd5) begin errors++; $display("[TB] FAIL br_cnt: got %h expected 5", dut.br_cnt); end
    checks++;
    if (dut.tk_cnt !== 32'd3) begin errors++; $display("[TB] FAIL tk_cnt: got %h expected 3", dut.tk_cnt); end
    bus.sel = 3'b011;
    collect_digits();
    checks++;
    if (seen_seg[0] !== 8'h92) begin errors++; $display("[TB] FAIL br_digit0: got %h expected 92", seen_seg[0]); end
    checks++;
    if (seen_seg[1] !== 8'hC0) begin errors++; $display("[TB] FAIL br_digit1: got %h expected C0", seen_seg[1]); end
    bus.sel = 3'b100;
    collect_digits();
    checks++;
    if (seen_seg[0] !== 8'hB0) begin errors++; $display("[TB] FAIL tk_digit0: got %h expected B0", seen_seg[0]); end
  endtask

  task automatic test_clr_priority;
    bus.run_sw = 1;
    bus.clr = 1;
    @(negedge clk);
    bus.clr = 0;
    bus.ins_valid = 1;
    repeat (7) @(negedge clk);
    checks++;
    if (dut.ins_cnt !== 32'd7) begin errors++; $display("[TB] FAIL ins_pre_clr: got %h expected 7", dut.ins_cnt); end
    bus.clr = 1;
    @(negedge clk);
    bus.clr = 0; bus.ins_valid = 0; bus.run_sw = 0;
    checks++;
    if (dut.ins_cnt !== 32'd0) begin errors++; $display("[TB] FAIL clr_ins: got %h expected 0", dut.ins_cnt); end
    checks++;
    if (dut.cyc_cnt !== 32'd0) begin errors++; $display("[TB] FAIL clr_cyc: got %h expected 0", dut.cyc_cnt); end
  endtask

  task automatic test_saturation;
    force dut.tk_cnt = 32'hFFFFFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.tk_cnt;
    bus.run_sw = 1; bus.br_valid = 1; bus.br_taken = 1;
    @(negedge clk);
    bus.run_sw = 0; bus.br_valid = 0; bus.br_taken = 0;
    checks++;
    if (dut.tk_cnt !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL tk_sat: got %h expected FFFFFFFF", dut.tk_cnt); end
    checks++;
    if (dut.br_cnt !== 32'd1) begin errors++; $display("[TB] FAIL br_after_sat: got %h expected 1", dut.br_cnt); end
    bus.sel = 3'b100;
    collect_digits();
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (seen_seg[k] !== 8'h8E) begin errors++; $display("[TB] FAIL sat_digit%0d: got %h expected 8E", k, seen_seg[k]); end
    end
    bus.clr = 1;
    @(negedge clk);
    bus.clr = 0;
    checks++;
    if (dut.tk_cnt !== 32'd0) begin errors++; $display("[TB] FAIL sat_clr: got %h expected 0", dut.tk_cnt); end
  endtask

  task automatic test_freeze;
    bus.sel = 3'b101;
    bus.run_sw = 1;
    bus.ins_valid = 1;
    repeat (4) @(negedge clk);
    bus.ins_valid = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (dut.disp_val !== 32'd4) begin errors++; $display("[TB] FAIL freeze_pre: got %h expected 4", dut.disp_val); end
    bus.freeze = 1;
    bus.ins_valid = 1;
    repeat (20) @(negedge clk);
    bus.ins_valid = 0;
    bus.run_sw = 0;
    checks++;
    if (dut.ins_cnt !== 32'd24) begin errors++; $display("[TB] FAIL freeze_ins: got %h expected 24", dut.ins_cnt); end
    checks++;
    if (dut.disp_val !== 32'd4) begin errors++; $display("[TB] FAIL freeze_hold: got %h expected 4", dut.disp_val); end
    collect_digits();
    checks++;
    if (seen_seg[0] !== 8'h99) begin errors++; $display("[TB] FAIL freeze_digit0: got %h expected 99", seen_seg[0]); end
    bus.freeze = 0;
    @(negedge clk);
    checks++;
    if (dut.disp_val !== 32'h18) begin errors++; $display("[TB] FAIL unfreeze: got %h expected 18", dut.disp_val); end
    collect_digits();
    checks++;
    if (seen_seg[0] !== 8'h80) begin errors++; $display("[TB] FAIL unfreeze_digit0: got %h expected 80", seen_seg[0]); end
    checks++;
    if (seen_seg[1] !== 8'hF9) begin errors++; $display("[TB] FAIL unfreeze_digit1: got %h expected F9", seen_seg[1]); end
  endtask

  task automatic test_mux_leds;
    logic [7:0] exp_a [8];
    logic [7:0] exp_b [8];
    exp_a = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
    exp_b = '{8'hC0, 8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90};
    bus.run_sw = 1; bus.in_addr = 12'hA5C; bus.sel = 3'b000;
    @(negedge clk);
    checks++;
    if (bus.leds !== {1'b1, 12'hA5C, 3'b000}) begin errors++; $display("[TB] FAIL leds_addr: got %h expected %h", bus.leds, {1'b1, 12'hA5C, 3'b000}); end
    checks++;
    if (dut.disp_val !== 32'h00000A5C) begin errors++; $display("[TB] FAIL mux_addr: got %h expected 00000A5C", dut.disp_val); end
    bus.sel = 3'b110;
    @(negedge clk);
    checks++;
    if (dut.disp_val !== 32'h0) begin errors++; $display("[TB] FAIL mux_110: got %h expected 0", dut.disp_val); end
    checks++;
    if (bus.leds !== {1'b1, 12'hA5C, 3'b110}) begin errors++; $display("[TB] FAIL leds_sel: got %h expected %h", bus.leds, {1'b1, 12'hA5C, 3'b110}); end
    bus.sel = 3'b001; bus.pc = 32'h12345678;
    collect_digits();
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (seen_seg[k] !== exp_a[k]) begin errors++; $display("[TB] FAIL pc_a_digit%0d: got %h expected %h", k, seen_seg[k], exp_a[k]); end
    end
    bus.pc = 32'h9ABCDEF0;
    collect_digits();
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (seen_seg[k] !== exp_b[k]) begin errors++; $display("[TB] FAIL pc_b_digit%0d: got %h expected %h", k, seen_seg[k], exp_b[k]); end
    end
  endtask

  task automatic test_reset_mid;
    bit found;
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (bus.an === 8'hDF) found = 1;
    end
    checks++;
    if (!found) begin errors++; $display("[TB] FAIL mid_wait_idx5: an=%h never reached DF", bus.an); end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.an !== 8'hFE) begin errors++; $display("[TB] FAIL mid_reset_an: got %h expected FE", bus.an); end
    checks++;
    if (bus.seg !== 8'hC0) begin errors++; $display("[TB] FAIL mid_reset_seg: got %h expected C0", bus.seg); end
    checks++;
    if (bus.leds !== 16'h0000) begin errors++; $display("[TB] FAIL mid_reset_leds: got %h expected 0000", bus.leds); end
    checks++;
    if (dut.cyc_cnt !== 32'h0) begin errors++; $display("[TB] FAIL mid_reset_cyc: got %h expected 0", dut.cyc_cnt); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_scan();
    test_cycle_count();
    test_branches();
    test_clr_priority();
    test_saturation();
    test_freeze();
    test_mux_leds();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
